trail_writer: RTL and testbench

TRAIL_WRITER -- requirements
Module: trail_writer

---
 rtl/trail_writer_if.sv | 13 +
 rtl/trail_writer.sv | 171 +++++++++++++++++
 tb/tb_trail_writer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/trail_writer_if.sv
// trail_writer_if -- frame buffer write port.
//   write_address : 19-bit frame buffer word address
//   Data_Out      : 16-bit word to write
//   WE            : write enable, one word per cycle while high
// master drives the write; slave is the frame buffer side.
interface trail_writer_if;
  logic [18:0] write_address;
  logic [15:0] Data_Out;
  logic        WE;

  modport master (output write_address, output Data_Out, output WE);
  modport slave  (input  write_address, input  Data_Out, input  WE);
endinterface

// File: rtl/trail_writer.sv
// trail_writer -- writes the two bike trail pixels into the frame buffer once
// per frame tick, and fills the whole buffer with the background colour on
// request.
//   Clk, Reset        : clock, synchronous active-high reset
//   frame_clk         : frame tick level; its rising edge starts a trail write
//   clear_req         : one-cycle request to clear the frame buffer
//   Blue/Red_X/Y_real : 10-bit pixel positions of the two bikes
//   blue/red_alive    : per-bike write enables
//   fb                : frame buffer write port (address, data, WE)
//   busy              : high whenever the writer is not idle
//   clear_done        : one-cycle pulse on the last word of a clear
// Each buffer word holds two horizontally adjacent pixels: even-X enum in
// [3:0], odd-X enum in [11:8]. A trail write sets both pixels of the pair.
module trail_writer #(
  parameter logic [3:0] BG_ENUM   = 4'h8,
  parameter logic [3:0] BLUE_ENUM = 4'h2,
  parameter logic [3:0] RED_ENUM  = 4'h4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_clk,
  input  logic                  clear_req,
  input  logic [9:0]            Blue_X_real,
  input  logic [9:0]            Blue_Y_real,
  input  logic [9:0]            Red_X_real,
  input  logic [9:0]            Red_Y_real,
  input  logic                  blue_alive,
  input  logic                  red_alive,
  trail_writer_if.master        fb,
  output logic                  busy,
  output logic                  clear_done
);

  typedef enum logic [1:0] {IDLE, CLEAR, WR_BLUE, WR_RED} state_t;

  // 640x480 pixels at two pixels per word.
  localparam logic [17:0] LAST_WORD = 18'd153599;

  localparam logic [15:0] BG_WORD   = {4'h0, BG_ENUM,   4'h0, BG_ENUM};
  localparam logic [15:0] BLUE_WORD = {4'h0, BLUE_ENUM, 4'h0, BLUE_ENUM};
  localparam logic [15:0] RED_WORD  = {4'h0, RED_ENUM,  4'h0, RED_ENUM};

  state_t      state_q, state_d;
  logic        frame_clk_q;
  logic        pend_q;
  logic [17:0] clr_cnt_q;
  logic [9:0]  bx_q, by_q, rx_q, ry_q;
  logic        ba_q, ra_q;

  logic        tick;
  logic        clear_go;
  logic        we;
  logic [18:0] addr;
  logic [15:0] data;
  logic        done;

  // Y*320 + X/2 built from shifts so no multiplier is needed.
  function automatic logic [18:0] pix_addr(input logic [8:0] x_half,
                                           input logic [9:0] y);
    return ({9'd0, y} << 8) + ({9'd0, y} << 6) + {10'd0, x_half};
  endfunction

  function automatic logic in_frame(input logic [9:0] x, input logic [9:0] y);
    return (x < 10'd640) && (y < 10'd480);
  endfunction

  assign tick     = frame_clk & ~frame_clk_q;
  assign clear_go = clear_req | pend_q;

  // NOTE: non-blocking assignments for every register so all state updates
  // see the pre-edge values, regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      frame_clk_q <= 1'b0;
      pend_q      <= 1'b0;
      clr_cnt_q   <= '0;
      bx_q        <= '0;
      by_q        <= '0;
      rx_q        <= '0;
      ry_q        <= '0;
      ba_q        <= 1'b0;
      ra_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_clk_q <= frame_clk;

      // Snapshot the positions on an accepted tick so a bike moving during
      // the write cannot split the blue/red pair across two frames.
      if (state_q == IDLE && tick && !clear_go) begin
        bx_q <= Blue_X_real;
        by_q <= Blue_Y_real;
        rx_q <= Red_X_real;
        ry_q <= Red_Y_real;
        ba_q <= blue_alive;
        ra_q <= red_alive;
      end

      // A clear requested mid-write is remembered and served from IDLE.
      if ((state_q == WR_BLUE || state_q == WR_RED) && clear_req)
        pend_q <= 1'b1;
      else if (state_q == IDLE)
        pend_q <= 1'b0;

      if (state_q == CLEAR)
        clr_cnt_q <= clr_cnt_q + 18'd1;
      else
        clr_cnt_q <= '0;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    we      = 1'b0;
    addr    = '0;
    data    = '0;
    done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Clear has priority; a tick in the same cycle is simply dropped.
        if (clear_go)  state_d = CLEAR;
        else if (tick) state_d = WR_BLUE;
      end
      CLEAR: begin
        we   = 1'b1;
        addr = {1'b0, clr_cnt_q};
        data = BG_WORD;
        if (clr_cnt_q == LAST_WORD) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      WR_BLUE: begin
        if (ba_q && in_frame(bx_q, by_q)) begin
          we   = 1'b1;
          addr = pix_addr(bx_q[9:1], by_q);
          data = BLUE_WORD;
        end
        state_d = WR_RED;
      end
      WR_RED: begin
        if (ra_q && in_frame(rx_q, ry_q)) begin
          we   = 1'b1;
          addr = pix_addr(rx_q[9:1], ry_q);
          data = RED_WORD;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset silences the port in the same cycle, before the state register
    // has had an edge to return to IDLE.
    if (Reset) begin
      we   = 1'b0;
      addr = '0;
      data = '0;
      done = 1'b0;
    end
  end

  assign fb.WE            = we;
  assign fb.write_address = addr;
  assign fb.Data_Out      = data;
  assign clear_done       = done;
  assign busy             = (state_q != IDLE) && !Reset;

endmodule

// File: tb/tb_trail_writer.sv
// tb_trail_writer -- scoreboard bench for trail_writer.
// Stimulus pushes every frame buffer write it expects (cycle, address, data,
// clear_done) into a queue; a monitor on the falling edge pops and compares
// each write the DUT issues and flags unexpected or missing writes.
module tb_trail_writer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic       clear_req;
  logic [9:0] bx, by, rx, ry;
  logic       ba, ra;
  logic       busy;
  logic       clear_done;

  trail_writer_if fb();

  trail_writer dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .clear_req   (clear_req),
    .Blue_X_real (bx),
    .Blue_Y_real (by),
    .Red_X_real  (rx),
    .Red_Y_real  (ry),
    .blue_alive  (ba),
    .red_alive   (ra),
    .fb          (fb),
    .busy        (busy),
    .clear_done  (clear_done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int cyc;
    int addr;
    int data;
    bit done;
  } wr_t;

  wr_t sb[$];
  int  cyc     = 0;
  int  n_tests = 0;
  int  n_fail  = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: frame of 640x480 pixels, two pixels per word.
  function automatic int ref_addr(input int x, input int y);
    return y * 320 + x / 2;
  endfunction

  function automatic bit ref_vis(input bit alive, input int x, input int y);
    return alive && x < 640 && y < 480;
  endfunction

  task automatic push_wr(input int c, input int a, input int d, input bit dn);
    wr_t e;
    e.cyc = c; e.addr = a; e.data = d; e.done = dn;
    sb.push_back(e);
  endtask

  task automatic push_clear(input int c_first, input int n_words);
    for (int i = 0; i < n_words; i++)
      push_wr(c_first + i, i, 16'h0808, i == 153599);
  endtask

  // Monitor: compare each issued write against the queue head.
  always @(negedge Clk) begin
    wr_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missing_write @cyc %0d: got no write, expected addr %0d data %0h at cyc %0d",
               cyc, e.addr, e.data, e.cyc);
    end
    if (fb.WE === 1'b1) begin
      if (sb.size() == 0 || sb[0].cyc != cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write @cyc %0d: got addr %0d data %0h, expected no write",
                 cyc, fb.write_address, fb.Data_Out);
      end else begin
        e = sb.pop_front();
        check("write_addr", fb.write_address, e.addr);
        check("write_data", fb.Data_Out, e.data);
        check("write_done", clear_done, e.done);
      end
    end else begin
      check("idle_port", {clear_done, fb.write_address, fb.Data_Out}, 0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step(1);
  endtask

  task automatic scramble();
    bx = 10'($urandom); by = 10'($urandom);
    rx = 10'($urandom); ry = 10'($urandom);
    ba = 1'($urandom);  ra = 1'($urandom);
  endtask

  // Raise frame_clk with the given positions, then disturb the inputs so only
  // the captured values can produce the expected writes.
  task automatic issue_tick(input int bx_i, input int by_i, input bit ba_i,
                            input int rx_i, input int ry_i, input bit ra_i);
    bx = 10'(bx_i); by = 10'(by_i); ba = ba_i;
    rx = 10'(rx_i); ry = 10'(ry_i); ra = ra_i;
    frame_clk = 1'b1;
    if (ref_vis(ba_i, bx_i, by_i)) push_wr(cyc + 1, ref_addr(bx_i, by_i), 16'h0202, 1'b0);
    if (ref_vis(ra_i, rx_i, ry_i)) push_wr(cyc + 2, ref_addr(rx_i, ry_i), 16'h0404, 1'b0);
    step(1);
    scramble();
    step(1);
    frame_clk = 1'b0;
    step(2);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge Clk);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, clear_done, 0);
    check({tag, "_we"}, fb.WE, 0);
    check({tag, "_addr"}, fb.write_address, 0);
    check({tag, "_data"}, fb.Data_Out, 0);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    Reset = 1'b1; frame_clk = 1'b0; clear_req = 1'b0;
    bx = '0; by = '0; rx = '0; ry = '0; ba = 1'b0; ra = 1'b0;
    step(2);
    check_reset_outputs("reset");
    Reset = 1'b0;
    step(2);

    // Directed trail write, both bikes alive.
    issue_tick(100, 50, 1'b1, 321, 479, 1'b1);

    // Red dead, blue just off the right edge: no writes, busy for two cycles.
    bx = 10'd640; by = 10'd10; ba = 1'b1;
    rx = 10'd20;  ry = 10'd20; ra = 1'b0;
    frame_clk = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("busy_window", busy, (i == 1 || i == 2));
    end
    @(posedge Clk); #1;
    frame_clk = 1'b0;
    step(2);

    // Randomised trail writes, including off-frame positions and dead bikes.
    for (int i = 0; i < 40; i++) begin
      issue_tick($urandom_range(0, 700), $urandom_range(0, 520), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 700), $urandom_range(0, 520), $urandom_range(0, 3) != 0);
      step($urandom_range(0, 2));
    end

    // Clear with a tick and a repeated request mid-way, aborted by reset.
    c0 = cyc;
    clear_req = 1'b1;
    push_clear(c0 + 1, 1001);
    step(1);
    clear_req = 1'b0;
    wait_until(c0 + 300);
    frame_clk = 1'b1;
    wait_until(c0 + 305);
    frame_clk = 1'b0;
    wait_until(c0 + 500);
    clear_req = 1'b1;
    step(1);
    clear_req = 1'b0;
    wait_until(c0 + 1002);
    Reset = 1'b1;
    check_reset_outputs("clear_abort");
    step(1);
    Reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      check("idle_after_reset", busy, 0);
    end
    @(posedge Clk); #1;

    // Clear and tick together: clear only. frame_clk stays high through a
    // reset, so release must produce a trail write.
    c0 = cyc;
    clear_req = 1'b1;
    frame_clk = 1'b1;
    push_clear(c0 + 1, 10);
    step(1);
    clear_req = 1'b0;
    wait_until(c0 + 11);
    Reset = 1'b1;
    step(2);
    bx = 10'd200; by = 10'd100; ba = 1'b1;
    rx = 10'd639; ry = 10'd479; ra = 1'b1;
    Reset = 1'b0;
    push_wr(cyc + 1, ref_addr(200, 100), 16'h0202, 1'b0);
    push_wr(cyc + 2, ref_addr(639, 479), 16'h0404, 1'b0);
    step(1);
    scramble();
    step(3);
    frame_clk = 1'b0;
    step(2);

    // Clear requested during WR_BLUE: trail completes, IDLE, then clear.
    c0 = cyc;
    bx = 10'd0; by = 10'd0; ba = 1'b1;
    rx = 10'd1; ry = 10'd1; ra = 1'b1;
    frame_clk = 1'b1;
    push_wr(c0 + 1, ref_addr(0, 0), 16'h0202, 1'b0);
    push_wr(c0 + 2, ref_addr(1, 1), 16'h0404, 1'b0);
    step(1);
    clear_req = 1'b1;
    step(1);
    clear_req = 1'b0;
    frame_clk = 1'b0;
    push_clear(c0 + 4, 20);
    wait_until(c0 + 3);
    @(negedge Clk);
    check("busy_gap_before_clear", busy, 0);
    @(posedge Clk); #1;
    wait_until(c0 + 24);
    Reset = 1'b1;
    step(2);
    Reset = 1'b0;
    step(5);

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
